// File: rtl/vga_display_controller_pkg.sv
// rtl/vga_display_controller_pkg.sv - shared VGA timing constants, pixel types and coordinate width
package vga_display_controller_pkg;

  // Coordinate width shared by the controller and every drawing object
  localparam int COORD_W = 11;

  // Default 640x480@60 timing (25 MHz pixel clock)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Pixel colour as produced by the objects mux: RRRGGGBB
  typedef logic [7:0] rgb332_t;

  // Pixel colour as driven to the DAC
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Per-pixel timing flags; all-zero means "blanked, no sync asserted"
  typedef struct packed {
    logic active;
    logic hs_on;
    logic vs_on;
  } timing_t;

endpackage

// File: rtl/vga_display_controller_if.sv
// rtl/vga_display_controller_if.sv - pixel coordinate / colour interface between controller and objects mux
interface vga_display_controller_if;
  import vga_display_controller_pkg::*;

  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               pixel_en;
  logic               startOfFrame;
  rgb332_t            RGBIn;

  // Controller side: publishes coordinates, takes back the mux colour
  modport master (
    output pixelX, pixelY, pixel_en, startOfFrame,
    input  RGBIn
  );

  // Objects mux side
  modport slave (
    input  pixelX, pixelY, pixel_en, startOfFrame,
    output RGBIn
  );

endinterface

// File: rtl/vga_rgb_expand.sv
// rtl/vga_rgb_expand.sv - 3-3-2 to 8-8-8 colour expansion by bit replication
module vga_rgb_expand
  import vga_display_controller_pkg::*;
(
  input  rgb332_t rgb_i,
  output rgb888_t rgb_o
);

  // Replicate each field MSB-first so 0 maps to 0x00 and full scale to 0xFF
  always_comb begin
    rgb_o.r = {rgb_i[7:5], rgb_i[7:5], rgb_i[7:6]};
    rgb_o.g = {rgb_i[4:2], rgb_i[4:2], rgb_i[4:3]};
    rgb_o.b = {rgb_i[1:0], rgb_i[1:0], rgb_i[1:0], rgb_i[1:0]};
  end

endmodule

// File: rtl/vga_display_controller.sv
// rtl/vga_display_controller.sv - VGA raster timing, coordinates and pin alignment; VGA_TEST_PATTERN_EN adds colour bars
module vga_display_controller
  import vga_display_controller_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                     test_pattern,
`endif
  vga_display_controller_if.master pix,
  output logic [7:0]               VGA_R,
  output logic [7:0]               VGA_G,
  output logic [7:0]               VGA_B,
  output logic                     VGA_HS,
  output logic                     VGA_VS,
  output logic                     VGA_BLANK_N
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // One slot of the alignment line; the x coordinate rides along only for the bars
  typedef struct packed {
`ifdef VGA_TEST_PATTERN_EN
    logic [COORD_W-1:0] x;
`endif
    timing_t t;
  } tap_t;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               div_last;
  logic               pixel_en_q, pixel_en_d;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               sof_q, sof_d;
  tap_t               raw;
  tap_t               stage_in;
  rgb332_t            rgb_src;
  rgb888_t            rgb_exp;
  rgb888_t            rgb_q, rgb_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_n_q, blank_n_d;

  // Pixel-rate divider; the strobe is registered so it lands on the last clk of each pixel
  always_comb begin
    div_last   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d  = div_last ? '0 : div_cnt_q + 1'b1;
    pixel_en_d = div_last;
  end

  // Raster counters step on the strobe; frame pulse coincides with the move to (0,0)
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    sof_d   = 1'b0;
    if (pixel_en_q) begin
      if (h_cnt_q == COORD_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        if (v_cnt_q == COORD_W'(V_TOTAL - 1)) begin
          v_cnt_d = '0;
          sof_d   = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Undelayed visibility and sync flags for the coordinate currently presented
  always_comb begin
    raw          = '0;
    raw.t.active = (h_cnt_q < COORD_W'(H_ACTIVE)) && (v_cnt_q < COORD_W'(V_ACTIVE));
    raw.t.hs_on  = (h_cnt_q >= COORD_W'(HS_START)) && (h_cnt_q < COORD_W'(HS_END));
    raw.t.vs_on  = (v_cnt_q >= COORD_W'(VS_START)) && (v_cnt_q < COORD_W'(VS_END));
`ifdef VGA_TEST_PATTERN_EN
    raw.x        = h_cnt_q;
`endif
  end

  // The output stage is the last of PIPE_DELAY stages, so only PIPE_DELAY-1 sit here
  generate
    if (PIPE_DELAY == 1) begin : g_no_dly
      assign stage_in = raw;
    end else begin : g_dly
      tap_t dly_q [PIPE_DELAY-1];

      // Shift the timing flags one slot per pixel
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY - 1; i++) dly_q[i] <= '0;
        end else if (pixel_en_q) begin
          dly_q[0] <= raw;
          for (int i = 1; i < PIPE_DELAY - 1; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign stage_in = dly_q[PIPE_DELAY-2];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  logic [2:0] bar_idx;

  // Bars are full-scale 3-3-2 codes so the shared expander turns them into 0x00/0xFF
  always_comb begin
    bar_idx = 3'(stage_in.x / COORD_W'(BAR_W));
    rgb_src = test_pattern ? {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}} : pix.RGBIn;
  end
`else
  assign rgb_src = pix.RGBIn;
`endif

  vga_rgb_expand u_expand (
    .rgb_i (rgb_src),
    .rgb_o (rgb_exp)
  );

  // Pin values for the pixel entering the output stage; colour forced black when blanked
  always_comb begin
    hs_d      = ~stage_in.t.hs_on;
    vs_d      = ~stage_in.t.vs_on;
    blank_n_d = stage_in.t.active;
    rgb_d     = stage_in.t.active ? rgb_exp : '0;
  end

  // All state: divider, counters, frame pulse and output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      pixel_en_q <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      sof_q      <= 1'b0;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pixel_en_q <= pixel_en_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      sof_q      <= sof_d;
      if (pixel_en_q) begin
        rgb_q     <= rgb_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= blank_n_d;
      end
    end
  end

  assign pix.pixelX       = h_cnt_q;
  assign pix.pixelY       = v_cnt_q;
  assign pix.pixel_en     = pixel_en_q;
  assign pix.startOfFrame = sof_q;
  assign VGA_R            = rgb_q.r;
  assign VGA_G            = rgb_q.g;
  assign VGA_B            = rgb_q.b;
  assign VGA_HS           = hs_q;
  assign VGA_VS           = vs_q;
  assign VGA_BLANK_N      = blank_n_q;

endmodule

// File: tb/tb_vga_display_controller.sv
// tb/tb_vga_display_controller.sv - randomized bench for vga_display_controller against a raster model
module tb_vga_display_controller;
  import vga_display_controller_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int H_ACTIVE   = 64;
  localparam int H_FP       = 4;
  localparam int H_SYNC     = 6;
  localparam int H_BP       = 6;
  localparam int V_ACTIVE   = 8;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 3;
  localparam int PIPE_DELAY = 2;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME      = H_TOTAL * V_TOTAL;
  localparam int FRAME_CLKS = FRAME * CLK_DIV;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_bn;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_pattern = 1'b0;
`endif

  vga_display_controller_if pix ();

  vga_display_controller #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PIPE_DELAY(PIPE_DELAY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .pix         (pix),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_bn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: clocks since release, strobes taken, expected pins
  int         t_clk = 0;
  int         n_en  = 0;
  bit         pe_m  = 0;
  bit         sof_m = 0;
  bit         tp_m  = 0;
  bit         rand_rgb = 1;
  logic [7:0] const_rgb = 8'h00;
  logic [7:0] rgb_drv = 8'h00;
  logic [7:0] er = 0, eg = 0, eb = 0;
  bit         ehs = 1, evs = 1, ebn = 0;
  bit         pin_ok = 0;
  int         pin_x = 0, pin_y = 0;

  bit counting = 0;
  int hs_low = 0, vs_low = 0, bn_high = 0, sof_cnt = 0;

  function automatic int xo(int n); return n % H_TOTAL; endfunction
  function automatic int yo(int n); return (n / H_TOTAL) % V_TOTAL; endfunction

  // Fill 8 bits by cycling through the field MSB-first
  function automatic logic [7:0] rep(logic [2:0] f, int w);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7-i] = f[w - 1 - (i % w)];
    return o;
  endfunction

  function automatic logic [23:0] expand(logic [7:0] c);
    return {rep(c[7:5], 3), rep(c[4:2], 3), rep({1'b0, c[1:0]}, 2)};
  endfunction

  function automatic logic [23:0] bar(int x);
    int idx;
    idx = x / (H_ACTIVE / 8);
    return {((idx >> 2) & 1) != 0 ? 8'hFF : 8'h00,
            ((idx >> 1) & 1) != 0 ? 8'hFF : 8'h00,
            (idx & 1) != 0 ? 8'hFF : 8'h00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pins_reset();
    er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; ebn = 0; pin_ok = 0;
  endtask

  // One clock: advance the model at the edge, drive new inputs, compare on the falling edge
  task automatic tick();
    int m, x, y;
    bit act;
    @(posedge clk);
    if (reset) begin
      t_clk = 0; n_en = 0; pe_m = 0; sof_m = 0;
      pins_reset();
    end else begin
      t_clk++;
      sof_m = 0;
      if (pe_m) begin
        n_en++;
        sof_m = (n_en % FRAME) == 0;
        m = n_en - PIPE_DELAY;
        if (m < 0) begin
          pins_reset();
        end else begin
          x = xo(m); y = yo(m);
          act = (x < H_ACTIVE) && (y < V_ACTIVE);
          ehs = !((x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC));
          evs = !((y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC));
          ebn = act;
          if (!act) {er, eg, eb} = 24'h0;
          else if (tp_m) {er, eg, eb} = bar(x);
          else {er, eg, eb} = expand(rgb_drv);
          pin_ok = 1; pin_x = x; pin_y = y;
        end
      end
      pe_m = (t_clk % CLK_DIV) == 0;
    end
    #1;
    rgb_drv   = rand_rgb ? 8'($urandom) : const_rgb;
    pix.RGBIn = rgb_drv;
`ifdef VGA_TEST_PATTERN_EN
    test_pattern = tp_m;
`endif
    @(negedge clk);
    chk("pixel_en", pix.pixel_en, pe_m);
    chk("pixelX", pix.pixelX, xo(n_en));
    chk("pixelY", pix.pixelY, yo(n_en));
    chk("startOfFrame", pix.startOfFrame, sof_m);
    chk("VGA_R", vga_r, er);
    chk("VGA_G", vga_g, eg);
    chk("VGA_B", vga_b, eb);
    chk("VGA_HS", vga_hs, ehs);
    chk("VGA_VS", vga_vs, evs);
    chk("VGA_BLANK_N", vga_bn, ebn);
    if (counting) begin
      hs_low  += (vga_hs == 1'b0) ? 1 : 0;
      vs_low  += (vga_vs == 1'b0) ? 1 : 0;
      bn_high += (vga_bn == 1'b1) ? 1 : 0;
      sof_cnt += (pix.startOfFrame == 1'b1) ? 1 : 0;
    end
  endtask

  // Run until the pins show visible-row pixel x, bounded
  task automatic wait_pin(input string name, input int x);
    int k = 0;
    while (!(pin_ok && pin_x == x && pin_y < V_ACTIVE) && k < 3 * FRAME_CLKS) begin
      tick(); k++;
    end
    if (!(pin_ok && pin_x == x && pin_y < V_ACTIVE)) begin
      checks++; errors++;
      $display("FAIL %s actual=timeout required=pins at x=%0d", name, x);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    pix.RGBIn = 8'h00;

    chk("model_e0", expand(8'hE0), 24'hFF0000);
    chk("model_49", expand(8'h49), 24'h494955);
    chk("model_ff", expand(8'hFF), 24'hFFFFFF);
    chk("model_bar1", bar(H_ACTIVE / 8), 24'h0000FF);

    repeat (3) tick();
    reset = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!pix.pixel_en && k < 8);
    chk("first_pe_clk", k, CLK_DIV);
    chk("first_pe_x", pix.pixelX, 0);
    repeat (4) tick();
    chk("px_run", pix.pixelX, 2);

    repeat (FRAME_CLKS) tick();

    rand_rgb = 0; const_rgb = 8'hE0;
    repeat (4 * CLK_DIV) tick();
    wait_pin("e0", 10);
    chk("e0_R", vga_r, 8'hFF); chk("e0_G", vga_g, 8'h00); chk("e0_B", vga_b, 8'h00);

    const_rgb = 8'h49;
    repeat (4 * CLK_DIV) tick();
    wait_pin("c49", 20);
    chk("c49_R", vga_r, 8'h49); chk("c49_G", vga_g, 8'h49); chk("c49_B", vga_b, 8'h55);

    const_rgb = 8'hFF;
    repeat (4 * CLK_DIV) tick();
    wait_pin("ff_blank", H_ACTIVE + 3);
    chk("ff_blank_R", vga_r, 8'h00); chk("ff_blank_B", vga_b, 8'h00);
    chk("ff_blank_N", vga_bn, 1'b0);
    rand_rgb = 1;

`ifdef VGA_TEST_PATTERN_EN
    tp_m = 1;
    repeat (4 * CLK_DIV) tick();
    wait_pin("tp_x0", 0);
    chk("tp_x0", {vga_r, vga_g, vga_b}, 24'h000000);
    wait_pin("tp_bar1", H_ACTIVE / 8);
    chk("tp_bar1", {vga_r, vga_g, vga_b}, 24'h0000FF);
    wait_pin("tp_last", H_ACTIVE - 1);
    chk("tp_last", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    tp_m = 0;
`endif

    k = 0;
    while (!(xo(n_en) == 30 && yo(n_en) == 5) && k < 2 * FRAME_CLKS) begin tick(); k++; end
    if (!(xo(n_en) == 30 && yo(n_en) == 5)) begin
      checks++; errors++;
      $display("FAIL midframe_wait actual=timeout required=coordinate 30,5");
    end
    #2 reset = 1'b1;
    #1;
    chk("rst_pixelX", pix.pixelX, 0);     chk("rst_pixelY", pix.pixelY, 0);
    chk("rst_pixel_en", pix.pixel_en, 0); chk("rst_sof", pix.startOfFrame, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_hs", vga_hs, 1); chk("rst_vs", vga_vs, 1); chk("rst_blank_n", vga_bn, 0);
    repeat (2) tick();
    reset = 1'b0;

    repeat (10) tick();
    counting = 1;
    repeat (2 * FRAME_CLKS) tick();
    counting = 0;
    chk("hs_low_clks", hs_low, 2 * V_TOTAL * H_SYNC * CLK_DIV);
    chk("vs_low_clks", vs_low, 2 * V_SYNC * H_TOTAL * CLK_DIV);
    chk("blank_n_high_clks", bn_high, 2 * H_ACTIVE * V_ACTIVE * CLK_DIV);
    chk("sof_per_2_frames", sof_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
